tag_lookup_ctrl: RTL and testbench

TAG_LOOKUP_CTRL -- requirements
Module: tag_lookup_ctrl

---
 rtl/tag_pkg.sv | 23 ++
 rtl/tag_match.sv | 24 ++
 rtl/tag_lookup_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_tag_lookup_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_pkg.sv
// Shared geometry, entry format and FSM state encoding for the tag lookup
// controller and its way comparator.
package tag_pkg;

  localparam int SETS = 128;           // number of sets
  localparam int WAYS = 8;             // number of ways
  localparam int TAGW = 19;            // tag width
  localparam int ENTW = TAGW + 1;      // stored entry = {valid, tag}
  localparam int SETW = $clog2(SETS);  // set index width

  typedef logic [ENTW-1:0] entry_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Builds a valid entry holding the given tag.
  function automatic entry_t make_entry(input logic [TAGW-1:0] tag);
    return {1'b1, tag};
  endfunction

endpackage

// File: rtl/tag_match.sv
// N-way tag comparator: a way matches when its entry is valid and its tag
// equals the lookup tag. Reports the match vector, any-hit and multi-hit.
module tag_match
  import tag_pkg::*;
(
  input  entry_t [WAYS-1:0] entries,
  input  logic [TAGW-1:0]   tag,
  output logic [WAYS-1:0]   way_oh,
  output logic              hit,
  output logic              multi
);

  // Per-way compare plus hit / more-than-one-hit reduction.
  always_comb begin
    way_oh = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_oh[w] = entries[w][ENTW-1] && (entries[w][TAGW-1:0] == tag);
    end
    hit   = |way_oh;
    // Clearing the lowest set bit leaves something only if two or more are set.
    multi = |(way_oh & (way_oh - WAYS'(1)));
  end

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Tag array controller: clears the array after reset, then serves 2-stage
// lookups (S0 issues the read, S1 compares) and single-cycle refill writes.
//
// Handshakes (req, resp, fill): a transfer happens on a rising edge where
// valid and ready are both high; valid must not depend on ready, and the
// payload must be stable while valid is high and ready is low.
//
// Optional feature: define TAG_BYPASS_EN to forward fills that hit the set
// being compared into the S1 compare instead of stalling the conflicting
// request or fill.
module tag_lookup_ctrl
  import tag_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            io_req_valid,
  output logic            io_req_ready,
  input  logic [SETW-1:0] io_req_set,
  input  logic [TAGW-1:0] io_req_tag,
  output logic            io_resp_valid,
  input  logic            io_resp_ready,
  output logic            io_resp_hit,
  output logic [WAYS-1:0] io_resp_wayOH,
  output logic            io_resp_multi,
  input  logic            io_fill_valid,
  output logic            io_fill_ready,
  input  logic [SETW-1:0] io_fill_set,
  input  logic [TAGW-1:0] io_fill_tag,
  input  logic [WAYS-1:0] io_fill_wayOH,
  output logic [SETW-1:0] io_arr_r_addr,
  input  logic [ENTW-1:0] io_arr_r_data_0,
  input  logic [ENTW-1:0] io_arr_r_data_1,
  input  logic [ENTW-1:0] io_arr_r_data_2,
  input  logic [ENTW-1:0] io_arr_r_data_3,
  input  logic [ENTW-1:0] io_arr_r_data_4,
  input  logic [ENTW-1:0] io_arr_r_data_5,
  input  logic [ENTW-1:0] io_arr_r_data_6,
  input  logic [ENTW-1:0] io_arr_r_data_7,
  output logic            io_arr_w_en,
  output logic [SETW-1:0] io_arr_w_addr,
  output logic [WAYS-1:0] io_arr_w_maskOH,
  output logic [ENTW-1:0] io_arr_w_data_0,
  output logic [ENTW-1:0] io_arr_w_data_1,
  output logic [ENTW-1:0] io_arr_w_data_2,
  output logic [ENTW-1:0] io_arr_w_data_3,
  output logic [ENTW-1:0] io_arr_w_data_4,
  output logic [ENTW-1:0] io_arr_w_data_5,
  output logic [ENTW-1:0] io_arr_w_data_6,
  output logic [ENTW-1:0] io_arr_w_data_7,
  output logic            io_init_busy,
  output state_t          dbg_state
);

  state_t            state;
  logic [SETW-1:0]   init_cnt;
  logic              s1_valid;
  logic [SETW-1:0]   s1_set;
  logic [TAGW-1:0]   s1_tag;

  logic              is_run;
  logic              s1_hold;
  logic              fill_fire;
  logic              req_fire;

  entry_t [WAYS-1:0] r_data;
  entry_t [WAYS-1:0] cmp_data;
  entry_t            w_data [WAYS];
  logic [WAYS-1:0]   match_oh;
  logic              match_hit;
  logic              match_multi;

  assign r_data = {io_arr_r_data_7, io_arr_r_data_6, io_arr_r_data_5, io_arr_r_data_4,
                   io_arr_r_data_3, io_arr_r_data_2, io_arr_r_data_1, io_arr_r_data_0};

  assign is_run  = (state == ST_RUN);
  // S1 is stuck while its response is offered but not taken.
  assign s1_hold = s1_valid && !io_resp_ready;

  // Fill and request acceptance, including the set-conflict interlocks.
  always_comb begin
`ifdef TAG_BYPASS_EN
    io_fill_ready = is_run;
`else
    // A fill to the set under compare would race the read data it relies on.
    io_fill_ready = is_run && !(s1_valid && (io_fill_set == s1_set));
`endif
    fill_fire    = io_fill_valid && io_fill_ready;
`ifdef TAG_BYPASS_EN
    io_req_ready = is_run && !s1_hold;
`else
    // The array returns pre-write data for a same-cycle write, so hold the
    // request off until the fill has landed.
    io_req_ready = is_run && !s1_hold && !(fill_fire && (io_fill_set == io_req_set));
`endif
    req_fire     = io_req_valid && io_req_ready;
  end

  // Read address: keep re-reading the S1 set while held so its data stays live.
  always_comb begin
    if (s1_hold) begin
      io_arr_r_addr = s1_set;
    end else if (is_run) begin
      io_arr_r_addr = io_req_set;
    end else begin
      io_arr_r_addr = '0;
    end
  end

  // Array write port: clear sweep during INIT, refill writes during RUN.
  always_comb begin
    io_arr_w_en     = 1'b0;
    io_arr_w_addr   = '0;
    io_arr_w_maskOH = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_data[w] = '0;
    end
    if (!is_run) begin
      io_arr_w_en     = 1'b1;
      io_arr_w_addr   = init_cnt;
      io_arr_w_maskOH = '1;
    end else if (fill_fire) begin
      io_arr_w_en     = 1'b1;
      io_arr_w_addr   = io_fill_set;
      io_arr_w_maskOH = io_fill_wayOH;
      for (int w = 0; w < WAYS; w++) begin
        w_data[w] = make_entry(io_fill_tag);
      end
    end
  end

  assign io_arr_w_data_0 = w_data[0];
  assign io_arr_w_data_1 = w_data[1];
  assign io_arr_w_data_2 = w_data[2];
  assign io_arr_w_data_3 = w_data[3];
  assign io_arr_w_data_4 = w_data[4];
  assign io_arr_w_data_5 = w_data[5];
  assign io_arr_w_data_6 = w_data[6];
  assign io_arr_w_data_7 = w_data[7];

  // Control FSM: INIT clears every set once, RUN advances the lookup pipe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      s1_valid <= 1'b0;
      s1_set   <= '0;
      s1_tag   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + SETW'(1);
          if (init_cnt == SETW'(SETS - 1)) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!s1_hold) begin
            s1_valid <= req_fire;
            if (req_fire) begin
              s1_set <= io_req_set;
              s1_tag <= io_req_tag;
            end
          end
        end
        default: begin
          state    <= ST_INIT;
          init_cnt <= '0;
        end
      endcase
    end
  end

`ifdef TAG_BYPASS_EN
  logic [WAYS-1:0] byp_valid;
  logic [TAGW-1:0] byp_tag [WAYS];
  logic            byp_issue;
  logic            byp_held;

  // Fill collides with the set entering S1, or with the set held in S1.
  assign byp_issue = req_fire && fill_fire && (io_fill_set == io_req_set);
  assign byp_held  = s1_hold && fill_fire && (io_fill_set == s1_set);

  // Per-way overlay flags: restart with each new lookup, accumulate while held.
  always_ff @(posedge clock) begin
    if (reset) begin
      byp_valid <= '0;
    end else if (req_fire) begin
      byp_valid <= byp_issue ? io_fill_wayOH : '0;
    end else if (byp_held) begin
      byp_valid <= byp_valid | io_fill_wayOH;
    end
  end

  // Overlay tags: latest fill tag per masked way.
  always_ff @(posedge clock) begin
    for (int w = 0; w < WAYS; w++) begin
      if ((byp_issue || byp_held) && io_fill_wayOH[w]) begin
        byp_tag[w] <= io_fill_tag;
      end
    end
  end

  // Compare data: forwarded fill entries take precedence over array data.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      cmp_data[w] = byp_valid[w] ? make_entry(byp_tag[w]) : r_data[w];
    end
  end
`else
  assign cmp_data = r_data;
`endif

  tag_match u_match (
    .entries (cmp_data),
    .tag     (s1_tag),
    .way_oh  (match_oh),
    .hit     (match_hit),
    .multi   (match_multi)
  );

  assign io_resp_valid = s1_valid;
  assign io_resp_hit   = s1_valid && match_hit;
  assign io_resp_wayOH = s1_valid ? match_oh : '0;
  assign io_resp_multi = s1_valid && match_multi;
  assign io_init_busy  = !is_run;
  assign dbg_state     = state;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed bench for tag_lookup_ctrl with a behavioural tag array (one-cycle
// read latency, read-before-write on a same-cycle address collision).
module tb_tag_lookup_ctrl;
  import tag_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic            io_req_valid = 1'b0;
  logic            io_req_ready;
  logic [SETW-1:0] io_req_set = '0;
  logic [TAGW-1:0] io_req_tag = '0;
  logic            io_resp_valid;
  logic            io_resp_ready = 1'b1;
  logic            io_resp_hit;
  logic [WAYS-1:0] io_resp_wayOH;
  logic            io_resp_multi;
  logic            io_fill_valid = 1'b0;
  logic            io_fill_ready;
  logic [SETW-1:0] io_fill_set = '0;
  logic [TAGW-1:0] io_fill_tag = '0;
  logic [WAYS-1:0] io_fill_wayOH = '0;
  logic [SETW-1:0] io_arr_r_addr;
  logic            io_arr_w_en;
  logic [SETW-1:0] io_arr_w_addr;
  logic [WAYS-1:0] io_arr_w_maskOH;
  logic            io_init_busy;
  state_t          dbg_state;
  entry_t          rd [WAYS];
  entry_t          wd [WAYS];

  tag_lookup_ctrl dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_set(io_req_set), .io_req_tag(io_req_tag),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_hit(io_resp_hit), .io_resp_wayOH(io_resp_wayOH), .io_resp_multi(io_resp_multi),
    .io_fill_valid(io_fill_valid), .io_fill_ready(io_fill_ready),
    .io_fill_set(io_fill_set), .io_fill_tag(io_fill_tag), .io_fill_wayOH(io_fill_wayOH),
    .io_arr_r_addr(io_arr_r_addr),
    .io_arr_r_data_0(rd[0]), .io_arr_r_data_1(rd[1]), .io_arr_r_data_2(rd[2]), .io_arr_r_data_3(rd[3]),
    .io_arr_r_data_4(rd[4]), .io_arr_r_data_5(rd[5]), .io_arr_r_data_6(rd[6]), .io_arr_r_data_7(rd[7]),
    .io_arr_w_en(io_arr_w_en), .io_arr_w_addr(io_arr_w_addr), .io_arr_w_maskOH(io_arr_w_maskOH),
    .io_arr_w_data_0(wd[0]), .io_arr_w_data_1(wd[1]), .io_arr_w_data_2(wd[2]), .io_arr_w_data_3(wd[3]),
    .io_arr_w_data_4(wd[4]), .io_arr_w_data_5(wd[5]), .io_arr_w_data_6(wd[6]), .io_arr_w_data_7(wd[7]),
    .io_init_busy(io_init_busy),
    .dbg_state(dbg_state)
  );

  // ---------------- tag array model ----------------
  entry_t mem [SETS][WAYS];
  always @(posedge clock) begin
    for (int w = 0; w < WAYS; w++) begin
      rd[w] <= mem[io_arr_r_addr][w];
      if (io_arr_w_en && io_arr_w_maskOH[w]) mem[io_arr_w_addr][w] <= wd[w];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];   // {hit, wayOH, multi}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Every taken response must match the oldest outstanding expectation.
  always begin
    @(negedge clock);
    #2;
    if (!reset && io_resp_valid && io_resp_ready) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'(io_resp_valid), 32'(0));
      end else begin
        check("resp_data", 32'({io_resp_hit, io_resp_wayOH, io_resp_multi}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals(input string tag);
    check({tag, "_resp_valid"}, 32'(io_resp_valid), 32'(0));
    check({tag, "_resp_fields"}, 32'({io_resp_hit, io_resp_wayOH, io_resp_multi}), 32'(0));
    check({tag, "_init_busy"}, 32'(io_init_busy), 32'(1));
    check({tag, "_w_en_addr_mask"}, 32'({io_arr_w_en, io_arr_w_addr, io_arr_w_maskOH}), 32'({1'b1, 7'd0, 8'hFF}));
    check({tag, "_r_addr"}, 32'(io_arr_r_addr), 32'(0));
    check({tag, "_readies"}, 32'({io_req_ready, io_fill_ready}), 32'(0));
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_INIT));
  endtask

  // Called in a cycle whose INIT counter is 0; follows the sweep to RUN.
  task automatic wait_init();
    int n = 0;
    logic [ENTW-1:0] orw;
    while (io_init_busy && n < 200) begin
      orw = '0;
      for (int w = 0; w < WAYS; w++) orw = orw | wd[w];
      check("init_write", 32'({io_arr_w_en, io_arr_w_addr, io_arr_w_maskOH}), 32'({1'b1, 7'(n), 8'hFF}));
      check("init_data", 32'(orw), 32'(0));
      n++;
      @(negedge clock);
      #1;
    end
    check("init_len", 32'(n), 32'(128));
    check("run_readies", 32'({io_req_ready, io_fill_ready, io_arr_w_en}), 32'({1'b1, 1'b1, 1'b0}));
    check("run_state", 32'(dbg_state), 32'(ST_RUN));
  endtask

  task automatic do_fill(input logic [6:0] s, input logic [18:0] t, input logic [7:0] way);
    int n = 0;
    @(negedge clock);
    io_fill_valid = 1'b1; io_fill_set = s; io_fill_tag = t; io_fill_wayOH = way;
    #1;
    while (!io_fill_ready && n < 20) begin @(negedge clock); #1; n++; end
    check("fill_ready_timeout", 32'(n < 20), 32'(1));
    check("fill_write", 32'({io_arr_w_en, io_arr_w_addr, io_arr_w_maskOH}), 32'({1'b1, s, way}));
    for (int w = 0; w < WAYS; w++) check("fill_data", 32'(wd[w]), 32'({1'b1, t}));
    @(posedge clock);
    #1 io_fill_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [6:0] s, input logic [18:0] t, input logic hit,
                           input logic [7:0] oh, input logic multi);
    int n = 0;
    @(negedge clock);
    io_req_valid = 1'b1; io_req_set = s; io_req_tag = t;
    #1;
    while (!io_req_ready && n < 20) begin @(negedge clock); #1; n++; end
    check("req_ready_timeout", 32'(n < 20), 32'(1));
    check("lookup_r_addr", 32'(io_arr_r_addr), 32'(s));
    exp_q.push_back({hit, oh, multi});
    @(posedge clock);
    #1 io_req_valid = 1'b0;
    @(negedge clock);
    #1 check("lookup_resp_valid", 32'(io_resp_valid), 32'(1));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        do_fill;
    logic [6:0]  f_set;
    logic [18:0] f_tag;
    logic [7:0]  f_way;
    logic [6:0]  l_set;
    logic [18:0] l_tag;
    logic        e_hit;
    logic [7:0]  e_oh;
    logic        e_multi;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 7'd5,   19'h01234, 8'h04, 7'd5,   19'h01234, 1'b1, 8'h04, 1'b0};
    vecs[1] = '{1'b0, 7'd0,   19'h00000, 8'h00, 7'd5,   19'h01235, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 7'd6,   19'h01234, 8'h01, 7'd6,   19'h01234, 1'b1, 8'h01, 1'b0};
    vecs[3] = '{1'b1, 7'd6,   19'h01234, 8'h10, 7'd6,   19'h01234, 1'b1, 8'h11, 1'b1};
    vecs[4] = '{1'b0, 7'd0,   19'h00000, 8'h00, 7'd0,   19'h00000, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 7'd127, 19'h7FFFF, 8'h80, 7'd127, 19'h7FFFF, 1'b1, 8'h80, 1'b0};
    vecs[6] = '{1'b0, 7'd0,   19'h00000, 8'h00, 7'd126, 19'h7FFFF, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 7'd6,   19'h00055, 8'h10, 7'd6,   19'h01234, 1'b1, 8'h01, 1'b0};

    // Reset state and the full clear sweep.
    repeat (2) @(negedge clock);
    #1 check_reset_vals("reset");
    reset = 1'b0;
    wait_init();

    // Table-driven fills and lookups.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_fill) do_fill(vecs[i].f_set, vecs[i].f_tag, vecs[i].f_way);
      do_lookup(vecs[i].l_set, vecs[i].l_tag, vecs[i].e_hit, vecs[i].e_oh, vecs[i].e_multi);
    end

    // Back-to-back lookups with the response held for three cycles.
    @(negedge clock);
    io_resp_ready = 1'b0;
    io_req_valid = 1'b1; io_req_set = 7'd5; io_req_tag = 19'h01234;
    #1 check("hold_first_ready", 32'(io_req_ready), 32'(1));
    exp_q.push_back({1'b1, 8'h04, 1'b0});
    @(posedge clock);
    #1 begin io_req_set = 7'd127; io_req_tag = 19'h7FFFF; end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1;
      check("hold_resp_valid", 32'(io_resp_valid), 32'(1));
      check("hold_resp_fields", 32'({io_resp_hit, io_resp_wayOH, io_resp_multi}), 32'({1'b1, 8'h04, 1'b0}));
      check("hold_req_ready", 32'(io_req_ready), 32'(0));
      check("hold_r_addr", 32'(io_arr_r_addr), 32'(5));
      if (k == 1) begin
        io_fill_valid = 1'b1; io_fill_set = 7'd5; io_fill_tag = 19'h01234; io_fill_wayOH = 8'h04;
        #1;
`ifdef TAG_BYPASS_EN
        check("hold_fill_ready", 32'(io_fill_ready), 32'(1));
`else
        check("hold_fill_ready", 32'(io_fill_ready), 32'(0));
`endif
        io_fill_valid = 1'b0;
      end
    end
    @(negedge clock);
    io_resp_ready = 1'b1;
    #1 check("release_req_ready", 32'(io_req_ready), 32'(1));
    exp_q.push_back({1'b1, 8'h80, 1'b0});
    @(posedge clock);
    #1 io_req_valid = 1'b0;
    @(negedge clock);
    #1 check("second_resp_valid", 32'(io_resp_valid), 32'(1));
    @(negedge clock);
    #1 check("no_duplicate_resp", 32'(io_resp_valid), 32'(0));
    #2 check("hold_queue_drained", 32'(exp_q.size()), 32'(0));

    // Same-cycle lookup and fill to set 9.
    @(negedge clock);
    io_req_valid = 1'b1; io_req_set = 7'd9; io_req_tag = 19'h00007;
    io_fill_valid = 1'b1; io_fill_set = 7'd9; io_fill_tag = 19'h00007; io_fill_wayOH = 8'h80;
    #1 check("haz_fill_ready", 32'(io_fill_ready), 32'(1));
`ifdef TAG_BYPASS_EN
    check("haz_req_ready", 32'(io_req_ready), 32'(1));
    exp_q.push_back({1'b1, 8'h80, 1'b0});
    @(posedge clock);
    #1 begin io_fill_valid = 1'b0; io_req_valid = 1'b0; end
`else
    check("haz_req_stall", 32'(io_req_ready), 32'(0));
    @(posedge clock);
    #1 io_fill_valid = 1'b0;
    @(negedge clock);
    #1 check("haz_req_ready_after", 32'(io_req_ready), 32'(1));
    exp_q.push_back({1'b1, 8'h80, 1'b0});
    @(posedge clock);
    #1 io_req_valid = 1'b0;
`endif
    @(negedge clock);
    #1 check("haz_resp_valid", 32'(io_resp_valid), 32'(1));

    // Reset in the middle of the clear sweep.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1 reset = 1'b0;
    repeat (60) @(negedge clock);
    #1 check("init60_addr", 32'(io_arr_w_addr), 32'(60));
    reset = 1'b1;
    @(negedge clock);
    #1 check_reset_vals("reinit");
    reset = 1'b0;
    wait_init();

    // Reset while S1 is held.
    do_fill(7'd5, 19'h01234, 8'h04);
    @(negedge clock);
    io_resp_ready = 1'b0;
    io_req_valid = 1'b1; io_req_set = 7'd5; io_req_tag = 19'h01234;
    @(posedge clock);
    #1 io_req_valid = 1'b0;
    @(negedge clock);
    #1 check("held_before_reset", 32'({io_resp_valid, io_resp_hit}), 32'(3));
    reset = 1'b1;
    @(negedge clock);
    #1 check_reset_vals("held_reset");
    reset = 1'b0;
    io_resp_ready = 1'b1;
    wait_init();

    // Array was cleared again: the old tag must now miss.
    do_lookup(7'd5, 19'h01234, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clock);
    #3 check("final_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
